sig_credit_rx: RTL and testbench



---
 rtl/sig_credit_rx.sv | 113 +++++++++++
 tb/tb_sig_credit_rx.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/sig_credit_rx.sv
// Credit-based receive buffer: valid-only input beats land in a DEPTH-entry FIFO, drain over valid/ready,
// and every freed entry returns one credit pulse. Define SIG_CREDIT_RX_BYPASS_EN for a zero-latency empty bypass.
module sig_credit_rx #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         sig_in_vld,
    input  logic [WIDTH-1:0]             sig_in,
    output logic                         sig_out_vld,
    input  logic                         sig_out_rdy,
    output logic [WIDTH-1:0]             sig_out,
    output logic                         crd_ret,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic                         ovf_err
);

    localparam int LW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam logic [LW-1:0] FULL = LW'(DEPTH);
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             crd_ret_q, crd_ret_d;
    logic             ovf_err_q, ovf_err_d;

    logic pop;
    logic pop_mem;
    logic push;
    logic byp_take;
    logic overflow;

    // Explicit compare so non-power-of-two depths wrap correctly.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
`ifdef SIG_CREDIT_RX_BYPASS_EN
        if (level_q == '0) begin
            sig_out_vld = sig_in_vld;
            sig_out     = sig_in;
        end else begin
            sig_out_vld = 1'b1;
            sig_out     = mem_q[rd_ptr_q];
        end
        byp_take = (level_q == '0) && sig_in_vld && sig_out_rdy;
`else
        sig_out_vld = (level_q != '0);
        sig_out     = mem_q[rd_ptr_q];
        byp_take    = 1'b0;
`endif
    end

    // A bypassed beat counts as a pop for credit purposes but never touches the array.
    always_comb begin
        pop      = sig_out_vld && sig_out_rdy;
        pop_mem  = pop && !byp_take;
        push     = sig_in_vld && ((level_q != FULL) || pop_mem) && !byp_take;
        overflow = sig_in_vld && (level_q == FULL) && !pop;
    end

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) begin
            mem_d[wr_ptr_q] = sig_in;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (pop_mem) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        case ({push, pop_mem})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
        crd_ret_d = pop;
        ovf_err_d = ovf_err_q || overflow;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            crd_ret_q <= 1'b0;
            ovf_err_q <= 1'b0;
        end else begin
            mem_q     <= mem_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            crd_ret_q <= crd_ret_d;
            ovf_err_q <= ovf_err_d;
        end
    end

    assign crd_ret = crd_ret_q;
    assign level   = level_q;
    assign ovf_err = ovf_err_q;

endmodule

// File: tb/tb_sig_credit_rx.sv
// Directed bench for sig_credit_rx (default build): a DEPTH=4 vector table plus a
// DEPTH=3 credit-driven streaming run checked against a queue model.
module tb_sig_credit_rx;

    logic       clk;
    logic       rst;

    logic       in_vld4, out_rdy4, out_vld4, crd4, ovf4;
    logic [3:0] din4, dout4;
    logic [2:0] lvl4;

    logic       in_vld3, out_rdy3, out_vld3, crd3, ovf3;
    logic [3:0] din3, dout3;
    logic [1:0] lvl3;

    int checks = 0;
    int errors = 0;

    sig_credit_rx #(.WIDTH(4), .DEPTH(4)) u_dut4 (
        .clk(clk), .rst(rst),
        .sig_in_vld(in_vld4), .sig_in(din4),
        .sig_out_vld(out_vld4), .sig_out_rdy(out_rdy4), .sig_out(dout4),
        .crd_ret(crd4), .level(lvl4), .ovf_err(ovf4)
    );

    sig_credit_rx #(.WIDTH(4), .DEPTH(3)) u_dut3 (
        .clk(clk), .rst(rst),
        .sig_in_vld(in_vld3), .sig_in(din3),
        .sig_out_vld(out_vld3), .sig_out_rdy(out_rdy3), .sig_out(dout3),
        .crd_ret(crd3), .level(lvl3), .ovf_err(ovf3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       vld;
        logic [3:0] din;
        logic       rdy;
        logic       exp_vld;
        logic       chk_out;
        logic [3:0] exp_out;
        logic       exp_crd;
        logic [2:0] exp_lvl;
        logic       exp_ovf;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mkVec(input logic r, input logic v, input logic [3:0] d, input logic rd,
                                   input logic ev, input logic co, input logic [3:0] eo,
                                   input logic ec, input logic [2:0] el, input logic eov);
        vec_t x;
        x.rst = r; x.vld = v; x.din = d; x.rdy = rd;
        x.exp_vld = ev; x.chk_out = co; x.exp_out = eo;
        x.exp_crd = ec; x.exp_lvl = el; x.exp_ovf = eov;
        return x;
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        rst      = v.rst;
        in_vld4  = v.vld;
        din4     = v.din;
        out_rdy4 = v.rdy;
    endtask

    initial begin
        int q[$];
        int credits;
        int sent;
        int received;
        int crd_total;
        logic       stalled;
        logic [3:0] held;
        string      tag;

        rst = 1'b1;
        in_vld4 = 0; din4 = 0; out_rdy4 = 0;
        in_vld3 = 0; din3 = 0; out_rdy3 = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        //                 rst vld din  rdy  vld chk out  crd lvl ovf
        vecs.push_back(mkVec(0, 0, 4'h0, 0,  0, 1, 4'h0, 0, 0, 0));
        vecs.push_back(mkVec(0, 1, 4'h5, 1,  0, 1, 4'h0, 0, 0, 0));
        vecs.push_back(mkVec(0, 0, 4'h0, 1,  1, 1, 4'h5, 0, 1, 0));
        vecs.push_back(mkVec(0, 0, 4'h0, 0,  0, 1, 4'h0, 1, 0, 0));
        vecs.push_back(mkVec(0, 0, 4'h0, 0,  0, 0, 4'h0, 0, 0, 0));
        vecs.push_back(mkVec(0, 1, 4'h1, 0,  0, 0, 4'h0, 0, 0, 0));
        vecs.push_back(mkVec(0, 1, 4'h2, 0,  1, 1, 4'h1, 0, 1, 0));
        vecs.push_back(mkVec(0, 1, 4'h3, 0,  1, 1, 4'h1, 0, 2, 0));
        vecs.push_back(mkVec(0, 1, 4'h4, 0,  1, 1, 4'h1, 0, 3, 0));
        vecs.push_back(mkVec(0, 1, 4'hA, 1,  1, 1, 4'h1, 0, 4, 0));
        vecs.push_back(mkVec(0, 1, 4'h9, 0,  1, 1, 4'h2, 1, 4, 0));
        vecs.push_back(mkVec(0, 0, 4'h0, 0,  1, 1, 4'h2, 0, 4, 1));
        vecs.push_back(mkVec(0, 0, 4'h0, 1,  1, 1, 4'h2, 0, 4, 1));
        vecs.push_back(mkVec(0, 0, 4'h0, 1,  1, 1, 4'h3, 1, 3, 1));
        vecs.push_back(mkVec(0, 0, 4'h0, 1,  1, 1, 4'h4, 1, 2, 1));
        vecs.push_back(mkVec(0, 0, 4'h0, 1,  1, 1, 4'hA, 1, 1, 1));
        vecs.push_back(mkVec(0, 0, 4'h0, 0,  0, 0, 4'h0, 1, 0, 1));
        vecs.push_back(mkVec(0, 0, 4'h0, 0,  0, 0, 4'h0, 0, 0, 1));
        vecs.push_back(mkVec(0, 1, 4'h7, 0,  0, 0, 4'h0, 0, 0, 1));
        vecs.push_back(mkVec(0, 1, 4'h8, 0,  1, 1, 4'h7, 0, 1, 1));
        vecs.push_back(mkVec(1, 0, 4'h0, 1,  1, 1, 4'h7, 0, 2, 1));
        vecs.push_back(mkVec(0, 0, 4'h0, 1,  0, 1, 4'h0, 0, 0, 0));
        vecs.push_back(mkVec(0, 0, 4'h0, 1,  0, 1, 4'h0, 0, 0, 0));

        foreach (vecs[i]) begin
            applyStimulus(vecs[i]);
            @(negedge clk);
            tag = $sformatf("v%0d", i);
            checkOutput({tag, "_vld"}, out_vld4, vecs[i].exp_vld);
            if (vecs[i].chk_out) checkOutput({tag, "_out"}, dout4, vecs[i].exp_out);
            checkOutput({tag, "_crd"}, crd4, vecs[i].exp_crd);
            checkOutput({tag, "_lvl"}, lvl4, vecs[i].exp_lvl);
            checkOutput({tag, "_ovf"}, ovf4, vecs[i].exp_ovf);
            @(posedge clk);
            #1;
        end
        applyStimulus(mkVec(0, 0, 4'h0, 0, 0, 0, 4'h0, 0, 0, 0));

        // DEPTH=3 stream: sender honours credits, downstream ready is random.
        credits = 3; sent = 0; received = 0; crd_total = 0;
        stalled = 1'b0; held = '0;
        for (int cyc = 0; cyc < 300 && !(received == 10 && crd_total == 10); cyc++) begin
            in_vld3  = (credits > 0) && (sent < 10);
            din3     = in_vld3 ? 4'(sent + 3) : 4'h0;
            out_rdy3 = ($urandom_range(0, 2) != 0);
            @(negedge clk);
            if (stalled && out_vld3) checkOutput("stable", dout3, held);
            if (crd3) begin
                credits++;
                crd_total++;
            end
            if (out_vld3 && out_rdy3) begin
                if (q.size() == 0) begin
                    checkOutput("unexpected_beat", 1, 0);
                end else begin
                    checkOutput("order", dout3, q.pop_front());
                end
                received++;
            end
            stalled = out_vld3 && !out_rdy3;
            held    = dout3;
            if (in_vld3) begin
                q.push_back(sent + 3);
                credits--;
                sent++;
            end
            @(posedge clk);
            #1;
        end
        in_vld3 = 0; out_rdy3 = 0;
        @(negedge clk);
        checkOutput("stream_rx", received, 10);
        checkOutput("stream_crd", crd_total, 10);
        checkOutput("stream_ovf", ovf3, 0);
        checkOutput("stream_lvl", lvl3, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
